// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle fetch/decode/execute/write control FSM.
// Fetches the word on instrucao, decodes it and drives the datapath enables.
// Optional feature macro: UC_PERF_CNT_EN adds the retired-instruction counter
// output instr_count[CNT_W-1:0]. Without it the port and counter are absent.
//
// state   | meaning
// --------+---------------------------------------------------
// OCIOSO  | idle, waiting for iniciar
// BUSCA   | latch instrucao into IR
// DECOD   | classify IR: zero word, illegal, or valid
// EXEC    | drive ALU controls from IR
// ESCRITA | one-cycle write enable plus pc_en, then next fetch
// HALT    | absorbing stop after an all-zero word
// ERRO    | absorbing stop after an illegal encoding
module unidade_controle #(
    parameter int INSTR_W = 32
`ifdef UC_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [INSTR_W-1:0] instrucao,
    output logic               pc_en,
    output logic               load_en,
    output logic               store_en,
    output logic [1:0]         op_ula,
    output logic               operation_type,
    output logic               ula_entry,
    output logic               parado,
    output logic               erro,
    output logic [2:0]         estado
`ifdef UC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   instr_count
`endif
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        BUSCA   = 3'd1,
        DECOD   = 3'd2,
        EXEC    = 3'd3,
        ESCRITA = 3'd4,
        HALT    = 3'd5,
        ERRO    = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_REG   = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;

    state_t             state, state_nxt;
    logic [INSTR_W-1:0] ir;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_ld, is_sd, is_add, is_sub, is_addi, is_subi;
    logic       is_valid, is_arith, is_sub_op;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    // Instruction classification from the latched IR
    always_comb begin
        is_ld   = (opcode == OPC_LOAD)  && (funct3 == 3'b011);
        is_sd   = (opcode == OPC_STORE) && (funct3 == 3'b011);
        is_add  = (opcode == OPC_REG)   && (funct3 == 3'b000) && (funct7 == 7'b0000000);
        is_sub  = (opcode == OPC_REG)   && (funct3 == 3'b000) && (funct7 == 7'b0100000);
        is_addi = (opcode == OPC_IMM)   && (funct3 == 3'b000);
        is_subi = (opcode == OPC_IMM)   && (funct3 == 3'b010);
        is_valid  = is_ld | is_sd | is_add | is_sub | is_addi | is_subi;
        is_arith  = is_add | is_sub | is_addi | is_subi;
        is_sub_op = is_sub | is_subi;
    end

    // State register and instruction register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OCIOSO;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == BUSCA) begin
                ir <= instrucao;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt      = state;
        pc_en          = 1'b0;
        load_en        = 1'b0;
        store_en       = 1'b0;
        op_ula         = 2'b00;
        operation_type = 1'b0;
        ula_entry      = 1'b0;
        parado         = 1'b0;
        erro           = 1'b0;
        case (state)
            OCIOSO: begin
                parado = 1'b1;
                if (iniciar) begin
                    state_nxt = BUSCA;
                end
            end
            BUSCA: begin
                state_nxt = DECOD;
            end
            DECOD: begin
                if (ir == '0) begin
                    state_nxt = HALT;
                end else if (!is_valid) begin
                    state_nxt = ERRO;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                op_ula         = is_sub_op ? 2'b00 : 2'b01;
                operation_type = is_arith;
                ula_entry      = is_sd | is_add | is_sub;
                state_nxt      = ESCRITA;
            end
            ESCRITA: begin
                op_ula         = is_sub_op ? 2'b00 : 2'b01;
                operation_type = is_arith;
                ula_entry      = is_sd | is_add | is_sub;
                load_en        = ~is_sd;
                store_en       = is_sd;
                pc_en          = 1'b1;
                state_nxt      = BUSCA;
            end
            HALT: begin
                parado = 1'b1;
            end
            ERRO: begin
                parado = 1'b1;
                erro   = 1'b1;
            end
            default: begin
                // Unused encoding: fail safe into the error trap.
                state_nxt = ERRO;
            end
        endcase
    end

    assign estado = state;

`ifdef UC_PERF_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Retired-instruction counter, one step per ESCRITA cycle, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == ESCRITA) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign instr_count = cnt;
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: randomized programs checked against an instruction-level
// reference model (decode table lookup plus fixed 4-cycle retirement timing).
module tb_unidade_controle;

`ifdef UC_PERF_CNT_EN
    localparam int CW = 2;
`endif

    logic        clk;
    logic        reset;
    logic        iniciar;
    logic [31:0] instrucao;
    logic        pc_en, load_en, store_en;
    logic [1:0]  op_ula;
    logic        operation_type, ula_entry, parado, erro;
    logic [2:0]  estado;
`ifdef UC_PERF_CNT_EN
    logic [CW-1:0] instr_count;
`endif

    unidade_controle #(
        .INSTR_W (32)
`ifdef UC_PERF_CNT_EN
        ,
        .CNT_W   (CW)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .iniciar        (iniciar),
        .instrucao      (instrucao),
        .pc_en          (pc_en),
        .load_en        (load_en),
        .store_en       (store_en),
        .op_ula         (op_ula),
        .operation_type (operation_type),
        .ula_entry      (ula_entry),
        .parado         (parado),
        .erro           (erro),
        .estado         (estado)
`ifdef UC_PERF_CNT_EN
        ,
        .instr_count    (instr_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         chk_f7;
        logic [1:0] ula;
        logic       typ;
        logic       ent;
        logic       st;
    } op_t;

    op_t tbl [6];

    int n_tests = 0;
    int n_fail  = 0;
    int n_bad   = 0;
    int retired = 0;
    int n_st_seen = 0;
    int n_pc_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bus-level invariants checked every cycle
    always @(negedge clk) begin
        if (load_en && store_en) n_bad++;
        if ((load_en || store_en) && !pc_en) n_bad++;
        if (pc_en && estado != 3'd4) n_bad++;
    end

    function automatic int find_op(input logic [31:0] w);
        for (int i = 0; i < 6; i++) begin
            if (w[6:0] == tbl[i].opc && w[14:12] == tbl[i].f3 &&
                (!tbl[i].chk_f7 || w[31:25] == tbl[i].f7))
                return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] mk(input int k);
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = tbl[k].opc;
        w[14:12] = tbl[k].f3;
        if (tbl[k].chk_f7) w[31:25] = tbl[k].f7;
        return w;
    endfunction

    function automatic logic [31:0] mk_illegal();
        logic [31:0] w;
        w = $urandom;
        while (w == 32'h0 || find_op(w) >= 0) w = $urandom;
        return w;
    endfunction

    task automatic do_reset();
        reset   = 1'b1;
        iniciar = 1'b0;
        instrucao = 32'h0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        retired = 0;
    endtask

    // Present one word at the reference negedge and check its whole effect
    task automatic retire_one(input logic [31:0] w);
        int  k;
        bit  seen;
        bit  any;
        k = find_op(w);
        instrucao = w;
        if (w == 32'h0 || k < 0) begin
            any = 1'b0;
            repeat (4) begin
                @(negedge clk);
                any = any | pc_en | load_en | store_en;
            end
            chk("stop_estado", {29'd0, estado}, (w == 32'h0) ? 32'd5 : 32'd6);
            chk("stop_parado", {31'd0, parado}, 32'd1);
            chk("stop_erro",   {31'd0, erro}, (w == 32'h0) ? 32'd0 : 32'd1);
            chk("stop_no_pulse", {31'd0, any}, 32'd0);
        end else begin
            seen = 1'b0;
            for (int c = 1; c <= 8 && !seen; c++) begin
                @(negedge clk);
                if (c == 3) begin
                    chk("exec_op_ula", {30'd0, op_ula}, {30'd0, tbl[k].ula});
                    chk("exec_type",   {31'd0, operation_type}, {31'd0, tbl[k].typ});
                    chk("exec_entry",  {31'd0, ula_entry}, {31'd0, tbl[k].ent});
                end
                if (pc_en) begin
                    seen = 1'b1;
                    chk("latency",  c, 4);
                    chk("load_en",  {31'd0, load_en},  {31'd0, ~tbl[k].st});
                    chk("store_en", {31'd0, store_en}, {31'd0, tbl[k].st});
                    chk("wr_op_ula", {30'd0, op_ula}, {30'd0, tbl[k].ula});
                    chk("wr_entry",  {31'd0, ula_entry}, {31'd0, tbl[k].ent});
`ifdef UC_PERF_CNT_EN
                    chk("instr_count", {30'd0, instr_count}, retired % (1 << CW));
`endif
                end
            end
            if (!seen) chk("pc_en_timeout", 32'd0, 32'd1);
            else begin
                retired++;
                n_pc_seen++;
                if (tbl[k].st) n_st_seen++;
            end
        end
    endtask

    initial begin
        logic [31:0] prog [$];
        bit any;
        int st0, pc0;

        tbl[0] = '{7'b0000011, 3'b011, 7'b0000000, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0}; // ld
        tbl[1] = '{7'b0100011, 3'b011, 7'b0000000, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1}; // sd
        tbl[2] = '{7'b0110011, 3'b000, 7'b0000000, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0}; // add
        tbl[3] = '{7'b0110011, 3'b000, 7'b0100000, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0}; // sub
        tbl[4] = '{7'b0010011, 3'b000, 7'b0000000, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0}; // addi
        tbl[5] = '{7'b0010011, 3'b010, 7'b0000000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0}; // subi

        // Reset state and idle hold
        reset = 1'b1; iniciar = 1'b0; instrucao = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_estado", {29'd0, estado}, 32'd0);
        chk("rst_parado", {31'd0, parado}, 32'd1);
        chk("rst_enables", {29'd0, pc_en, load_en, store_en}, 32'd0);
        chk("rst_erro",   {31'd0, erro}, 32'd0);
        chk("rst_alu",    {28'd0, op_ula, operation_type, ula_entry}, 32'd0);
        reset = 1'b0; retired = 0;
        repeat (5) @(negedge clk);
        chk("idle_estado", {29'd0, estado}, 32'd0);
        chk("idle_parado", {31'd0, parado}, 32'd1);
`ifdef UC_PERF_CNT_EN
        chk("idle_count", {30'd0, instr_count}, 32'd0);
`endif

        // Single ld x1,7(x0)
        iniciar = 1'b1;
        retire_one(32'h0070_3083);
        retire_one(32'h0);

        // Directed program: ld, add, sub, addi, subi, sd, zero word
        do_reset();
        st0 = n_st_seen; pc0 = n_pc_seen;
        iniciar = 1'b1;
        retire_one(mk(0)); retire_one(mk(2)); retire_one(mk(3));
        retire_one(mk(4)); retire_one(mk(5)); retire_one(mk(1));
        retire_one(32'h0);
        chk("prog_pc_pulses", n_pc_seen - pc0, 6);
        chk("prog_st_pulses", n_st_seen - st0, 1);
`ifdef UC_PERF_CNT_EN
        repeat (3) @(negedge clk);
        chk("halt_count_frozen", {30'd0, instr_count}, 6 % (1 << CW));
`endif

        // Illegal opcode, then reset clears the trap
        do_reset();
        iniciar = 1'b1;
        retire_one(32'h0000_007F);
        do_reset();
        @(negedge clk);
        chk("erro_clr_estado", {29'd0, estado}, 32'd0);
        chk("erro_clr_erro",   {31'd0, erro}, 32'd0);

        // Reset during EXEC of sd
        iniciar = 1'b1;
        instrucao = mk(1);
        any = 1'b0;
        repeat (3) begin
            @(negedge clk);
            any = any | pc_en | store_en;
        end
        chk("mid_exec_estado", {29'd0, estado}, 32'd3);
        reset = 1'b1; iniciar = 1'b0;
        @(negedge clk);
        any = any | pc_en | store_en;
        chk("mid_rst_estado", {29'd0, estado}, 32'd0);
        reset = 1'b0; retired = 0;
        repeat (3) begin
            @(negedge clk);
            any = any | pc_en | store_en;
        end
        chk("mid_rst_no_pulse", {31'd0, any}, 32'd0);
`ifdef UC_PERF_CNT_EN
        chk("mid_rst_count", {30'd0, instr_count}, 32'd0);
`endif

        // Randomized programs with a zero-word or illegal terminator
        for (int r = 0; r < 12; r++) begin
            prog.delete();
            for (int i = 0; i < $urandom_range(2, 8); i++) prog.push_back(mk($urandom_range(0, 5)));
            prog.push_back(($urandom_range(0, 1) == 0) ? 32'h0 : mk_illegal());
            do_reset();
            iniciar = 1'b1;
            foreach (prog[i]) retire_one(prog[i]);
        end

        chk("bus_invariants", n_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
